// File: rtl/channel_dispatcher_if.sv
// Bundle for the dispatcher: one valid/ready input stream with a destination id,
// and eight packed valid/ready output channels with occupancy and an accept counter.
interface channel_dispatcher_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [2:0]            in_dest;
    logic [7:0]            out_valid;
    logic [7:0]            out_ready;
    logic [8*DATA_W-1:0]   out_data;
    logic [8*CW-1:0]       ch_count;
    logic [15:0]           accept_cnt;

    modport master (
        output in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data, ch_count, accept_cnt
    );

    modport slave (
        input  in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data, ch_count, accept_cnt
    );
endinterface

// File: rtl/channel_dispatcher.sv
// Routes one input stream into eight per-channel circular FIFOs, each draining
// through its own valid/ready output; a stalled channel never blocks the others.
module channel_dispatcher #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    channel_dispatcher_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]          w_full;
    logic [7:0]          w_push;
    logic                w_in_ready;
    logic                w_accept;
    logic [8*DATA_W-1:0] w_out_data;
    logic [8*CW-1:0]     w_ch_count;
    logic [7:0]          w_out_valid;
    logic [15:0]         r_accept_cnt;

    // Readiness looks only at the addressed channel, never at in_valid or out_ready.
    assign w_in_ready = ~w_full[bus.in_dest];
    assign w_accept   = bus.in_valid && w_in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [AW-1:0]     r_wptr;
            logic [AW-1:0]     r_rptr;
            logic [CW-1:0]     r_count;
            logic              w_pop;
            logic              w_nonempty;

            assign w_nonempty  = (r_count != '0);
            assign w_full[gi]  = (r_count == CW'(DEPTH));
            assign w_push[gi]  = w_accept && (bus.in_dest == 3'(gi));
            assign w_pop       = w_nonempty && bus.out_ready[gi];

            // Storage has no reset so it can map onto distributed RAM.
            always_ff @(posedge clock) begin
                if (w_push[gi]) begin
                    r_mem[r_wptr] <= bus.in_data;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + AW'(1);
                    end
                    case ({w_push[gi], w_pop})
                        2'b10:   r_count <= r_count + CW'(1);
                        2'b01:   r_count <= r_count - CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign w_out_valid[gi]                  = w_nonempty;
            assign w_out_data[gi*DATA_W +: DATA_W]  = w_nonempty ? r_mem[r_rptr] : '0;
            assign w_ch_count[gi*CW +: CW]          = r_count;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_accept_cnt <= '0;
        end else if (w_accept) begin
            r_accept_cnt <= r_accept_cnt + 16'd1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_data;
    assign bus.ch_count   = w_ch_count;
    assign bus.accept_cnt = r_accept_cnt;
endmodule

// File: tb/tb_channel_dispatcher.sv
// Randomized and directed bench for channel_dispatcher, checked each cycle against
// a queue-per-channel reference model.
module tb_channel_dispatcher;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    channel_dispatcher_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    channel_dispatcher #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic [DW-1:0] mq   [8][$];
    logic [DW-1:0] plog [8][$];
    logic [15:0]   m_acc = 16'd0;
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  verbose = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] d, input logic [DW-1:0] data,
                         input logic [7:0] ordy);
        bus.in_valid  = v;
        bus.in_dest   = d;
        bus.in_data   = data;
        bus.out_ready = ordy;
    endtask

    task automatic drive_rand();
        drive(1'($urandom), 3'($urandom), $urandom, 8'($urandom));
    endtask

    function automatic logic [DW-1:0] head(input int k);
        return (mq[k].size() != 0) ? mq[k][0] : '0;
    endfunction

    // Compare the DUT against the model, then advance the model across one edge.
    task automatic tick();
        bit        acc;
        bit [7:0]  pop;
        bit        rs;
        logic [7:0] exp_valid;
        #1;
        exp_valid = '0;
        for (int k = 0; k < 8; k++) exp_valid[k] = (mq[k].size() != 0);
        chk("in_ready", 64'(bus.in_ready), 64'(mq[bus.in_dest].size() < DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("accept_cnt", 64'(bus.accept_cnt), 64'(m_acc));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("out_data[%0d]", k), 64'(bus.out_data[k*DW +: DW]), 64'(head(k)));
            chk($sformatf("ch_count[%0d]", k), 64'(bus.ch_count[k*CW +: CW]), 64'(mq[k].size()));
        end
        rs  = rst;
        acc = bus.in_valid && (mq[bus.in_dest].size() < DEPTH);
        for (int k = 0; k < 8; k++) pop[k] = bus.out_ready[k] && (mq[k].size() != 0);
        @(posedge clk);
        if (rs) begin
            for (int k = 0; k < 8; k++) begin
                mq[k].delete();
            end
            m_acc = 16'd0;
            if (verbose) $display("[TB] reset edge");
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (pop[k]) begin
                    plog[k].push_back(bus.out_data[k*DW +: DW]);
                    if (verbose) $display("[TB] pop  ch%0d data=0x%0h", k, bus.out_data[k*DW +: DW]);
                    void'(mq[k].pop_front());
                end
            end
            if (acc) begin
                mq[bus.in_dest].push_back(bus.in_data);
                m_acc = m_acc + 16'd1;
                if (verbose) $display("[TB] push ch%0d data=0x%0h", bus.in_dest, bus.in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_log(input int k, input string name, input int first, input int n);
        chk({name, "_len"}, 64'(plog[k].size()), 64'(n));
        for (int i = 0; i < n && i < plog[k].size(); i++)
            chk($sformatf("%s[%0d]", name, i), 64'(plog[k][i]), 64'(first + i));
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 8; k++) plog[k].delete();
    endtask

    initial begin
        int idx;
        drive(1'b0, 3'd0, '0, 8'h00);
        @(posedge clk);
        @(negedge clk);

        // Reset held with random traffic
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, '0, 8'h00);
        tick();

        // Routing to all eight channels
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), DW'(32'hA0 + k), 8'h00);
            tick();
        end
        drive(1'b0, 3'd0, '0, 8'h00);
        #1;
        chk("route_valid", 64'(bus.out_valid), 64'h FF);
        chk("route_acc", 64'(bus.accept_cnt), 64'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("route_head%0d", k), 64'(bus.out_data[k*DW +: DW]), 64'(32'hA0 + k));
        tick();
        drive(1'b0, 3'd0, '0, 8'hFF);
        tick();
        drive(1'b0, 3'd0, '0, 8'h00);
        #1;
        chk("route_drained", 64'(bus.out_valid), 64'h00);
        tick();

        // Full channel 3, backpressure, and bypass to another channel
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd3, DW'(32'h10 + i), 8'hF7);
            tick();
        end
        drive(1'b1, 3'd3, DW'(32'h14), 8'hF7);
        #1;
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        chk("full_count3", 64'(bus.ch_count[3*CW +: CW]), 64'd4);
        tick();
        drive(1'b1, 3'd5, DW'(32'h77), 8'hF7);
        #1;
        chk("other_ready", 64'(bus.in_ready), 64'd1);
        tick();
        idx = 32'h14;
        for (int c = 0; c < 20 && idx <= 32'h15; c++) begin
            drive(1'b1, 3'd3, DW'(idx), 8'hFF);
            if (mq[3].size() < DEPTH) idx++;
            tick();
        end
        chk("full_resume_done", 64'(idx), 64'h16);
        drive(1'b0, 3'd0, '0, 8'hFF);
        for (int i = 0; i < 6; i++) tick();
        check_log(3, "ch3_order", 32'h10, 6);

        // Simultaneous push and pop on channel 2
        clear_logs();
        drive(1'b1, 3'd2, DW'(32'h20), 8'h00); tick();
        drive(1'b1, 3'd2, DW'(32'h21), 8'h00); tick();
        drive(1'b1, 3'd2, DW'(32'h22), 8'h04); tick();
        drive(1'b0, 3'd2, '0, 8'h00);
        #1;
        chk("pushpop_count2", 64'(bus.ch_count[2*CW +: CW]), 64'd2);
        drive(1'b1, 3'd2, DW'(32'h23), 8'h00); tick();
        drive(1'b1, 3'd2, DW'(32'h24), 8'h00); tick();
        drive(1'b1, 3'd2, DW'(32'h25), 8'h04);
        #1;
        chk("fullpop_ready_now", 64'(bus.in_ready), 64'd0);
        tick();
        #1;
        chk("fullpop_ready_next", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 3'd0, '0, 8'hFF);
        for (int i = 0; i < 5; i++) tick();
        check_log(2, "ch2_order", 32'h20, 6);

        // Pointer wrap on channel 6
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'd6, DW'(i), 8'hFF);
            tick();
        end
        drive(1'b0, 3'd0, '0, 8'hFF);
        tick();
        check_log(6, "ch6_wrap", 0, 20);

        // Random traffic
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            tick();
        end
        verbose = 1'b1;
        drive(1'b0, 3'd0, '0, 8'hFF);
        for (int i = 0; i < 6; i++) tick();

        // Reset in the middle of buffered traffic
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd1, DW'(32'h31 + i), 8'h00); tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd7, DW'(32'h71 + i), 8'h00); tick();
        end
        rst = 1'b1;
        drive_rand();
        tick();
        rst = 1'b0;
        drive(1'b0, 3'd0, '0, 8'h00);
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'h00);
        chk("midrst_acc", 64'(bus.accept_cnt), 64'd0);
        tick();
        drive(1'b1, 3'd1, DW'(32'h55), 8'h00);
        tick();
        drive(1'b0, 3'd0, '0, 8'h00);
        #1;
        chk("midrst_head1", 64'(bus.out_data[1*DW +: DW]), 64'h55);
        chk("midrst_valid1", 64'(bus.out_valid), 64'h02);
        tick();

        // accept_cnt wrap
        verbose = 1'b0;
        for (int i = 0; i < 70000 && m_acc != 16'hFFFF; i++) begin
            drive(1'b1, 3'($urandom), $urandom, 8'hFF);
            tick();
        end
        verbose = 1'b1;
        drive(1'b0, 3'd0, '0, 8'hFF);
        #1;
        chk("acc_ffff", 64'(bus.accept_cnt), 64'hFFFF);
        tick();
        drive(1'b1, 3'd4, DW'(32'hEE), 8'hFF);
        tick();
        drive(1'b0, 3'd0, '0, 8'hFF);
        #1;
        chk("acc_wrap", 64'(bus.accept_cnt), 64'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/channel_dispatcher.md
# channel_dispatcher

Eight-way output dispatcher: accepts one valid/ready input stream in which every word carries a 3-bit destination channel id, and routes each word into a per-channel FIFO that drives one of eight independent valid/ready output channels. It is the fan-out counterpart to the 8-to-1 channel merger already in the design. It sits downstream of the merged output stream and restores per-channel traffic, with per-channel buffering so that one stalled consumer never blocks words bound for other channels.

## Interface
- DATA_W, 32, width of each data word
- DEPTH, 4, entries per channel FIFO; power of two, at least 2
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock
- in_valid  input  1  input word present
- in_ready  output  1  dispatcher can accept the word presented this cycle
- in_data  input  DATA_W  input word
- in_dest  input  3  destination channel, 0..7
- out_valid  output  8  bit k: channel k FIFO non-empty
- out_ready  input  8  bit k: channel k consumer accepts its head word
- out_data  output  8*DATA_W  channel k head word in bits [k*DATA_W +: DATA_W]
- ch_count  output  8*($clog2(DEPTH)+1)  per-channel occupancy, packed the same way as out_data
- accept_cnt  output  16  total input words accepted since reset; wraps 0xFFFF -> 0x0000

## Operation
- Each channel has a DEPTH-entry circular FIFO: registered storage, write pointer, read pointer, and an occupancy counter 0..DEPTH.
- in_ready = NOT full[in_dest]. This is combinational from in_dest and registered state only; it never depends on in_valid or out_ready.
- Input handshake: a word is accepted when in_valid && in_ready at a rising edge. It is written to FIFO[in_dest], that channel's write pointer advances modulo DEPTH, and accept_cnt increments.
- Output handshake for channel k: the head word is popped when out_valid[k] && out_ready[k] at a rising edge, and the read pointer advances modulo DEPTH.
- out_valid[k] = (count[k] != 0). out_data for channel k is the head entry when valid and all-zero when empty.
- Push and pop on the same channel in the same cycle:
  - Allowed whenever the channel is not full: count is unchanged and both pointers advance.
  - When the channel is full, in_ready is 0, so only the pop happens. There is no bypass of a full FIFO.
- Pops on different channels in one cycle are independent; any subset of the eight may pop.
- in_valid=0 with out_ready asserted on empty channels has no effect.
- The producer must hold in_data and in_dest stable while in_valid=1 and in_ready=0. The block does not check this.
- Word order within a channel is preserved. No ordering is guaranteed across channels.

## Timing
- Reset values, held while reset=1 and on the first cycle after it deasserts:
  - all FIFOs empty with pointers = 0
  - out_valid = 8'h00, out_data = 0, ch_count = 0, accept_cnt = 0
  - in_ready = 1
- Latency: a word accepted at edge N is visible on out_valid/out_data of its channel in the cycle after edge N. Minimum input-to-output latency is 1 cycle.
- Throughput: 1 input word per cycle while the destination FIFO is not full; each output can pop 1 word per cycle.
- A full channel's in_ready rises in the cycle after the edge that pops it.
- ch_count reflects all pushes and pops up to and including the last edge.
- Reset asserted mid-traffic: at the next edge all buffered words are discarded and every output returns to its reset value, regardless of in_valid and out_ready.

## Test plan
- Reset/idle: hold reset for 3 cycles with random in_valid and out_ready -> out_valid=0, out_data=0, accept_cnt=0, in_ready=1 throughout.
- Routing: send 0xA0+k to dest k for k=0..7 on consecutive cycles with out_ready=8'h00 -> out_valid=8'hFF, channel k head = 0xA0+k, accept_cnt=8. Then set out_ready=8'hFF for one cycle -> all channels empty, out_valid=8'h00.
- Full/backpressure: out_ready[3]=0, send 0x10..0x15 to dest 3 -> first 4 accepted, in_ready=0 while in_dest=3, ch_count[3]=4. Present dest 5 while channel 3 is full -> in_ready=1 and accepted. Release out_ready[3] -> drains in order 0x10,0x11,0x12,0x13, then 0x14 and 0x15 are accepted.
- Simultaneous push/pop: channel 2 holds 2 words; push to dest 2 while popping 2 -> ch_count[2] stays 2 and order is preserved. With channel 2 full and popping, present dest 2 -> in_ready=0 that cycle and 1 the next.
- Wrap-around: stream 20 words 0..19 to dest 6 with out_ready[6]=1 -> outputs 0..19 in order and pointers wrap 5 times. Preload accept_cnt to 0xFFFF via 65535 accepts, accept one more -> accept_cnt=0x0000.
- Mid-operation reset: 3 words buffered in channel 1 and 2 in channel 7, assert reset for 1 cycle -> all FIFOs empty next cycle. Subsequent word 0x55 to dest 1 appears as channel 1 head, not stale data.
